// File: rtl/rstatus_unit.sv
// rstatus_unit: owner of $r30 (status); bex query, $r30 write-back and event log FIFO. Optional: RSTATUS_STICKY_EN.
// Latency: status, rs_we/rs_data and bex outputs update one cycle after the triggering edge.
// Backpressure: evt_valid/evt_ready pops the log; a full log drops new events and sets sticky evt_drop.
module rstatus_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ovf_valid,
  input  logic [1:0]       ovf_code,
  input  logic             setx_valid,
  input  logic [26:0]      setx_target,
  input  logic             bex_req,
  output logic             bex_taken,
  output logic [26:0]      bex_target,
  output logic             bex_done,
  output logic             rs_we,
  output logic [31:0]      rs_data,
  output logic [31:0]      status,
  output logic             evt_valid,
  output logic [33:0]      evt_data,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] ovf_count,
  output logic             evt_drop
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             acc_ovf;
  logic             acc_setx;
  logic             accepted;
  logic             held;
  logic             upd;
  logic [31:0]      new_status;
  logic [1:0]       evt_type;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             pop;
  logic             push;
  logic [33:0]      mem [DEPTH];
  logic [33:0]      last_head;

  always_comb begin
    acc_ovf  = ovf_valid && (ovf_code != 2'd0);
    acc_setx = setx_valid && !acc_ovf;
    accepted = acc_ovf || acc_setx;
`ifdef RSTATUS_STICKY_EN
    held = (status[1:0] != 2'd0) && (status[31:2] == 30'd0);
`else
    held = 1'b0;
`endif
    new_status = status;
    evt_type   = 2'b00;
    upd        = 1'b0;
    if (acc_ovf) begin
      // A held code is logged as-is but never rewritten to the register file.
      evt_type = 2'b01;
      upd      = !held;
      if (!held) new_status = {30'd0, ovf_code};
    end else if (acc_setx) begin
      evt_type   = 2'b10;
      upd        = 1'b1;
      new_status = {5'd0, setx_target};
    end
  end

  // DEPTH is a power of two, so the count MSB alone marks a full log.
  assign full      = count[PTR_W];
  assign evt_valid = (count != '0);
  assign pop       = evt_valid && evt_ready;
  assign push      = accepted && (!full || pop);
  assign evt_data  = evt_valid ? mem[rd_ptr] : last_head;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      status     <= 32'd0;
      rs_we      <= 1'b0;
      rs_data    <= 32'd0;
      bex_taken  <= 1'b0;
      bex_target <= 27'd0;
      bex_done   <= 1'b0;
      ovf_count  <= '0;
      evt_drop   <= 1'b0;
    end else begin
      rs_we    <= upd;
      bex_done <= bex_req;
      if (upd) begin
        status  <= new_status;
        rs_data <= new_status;
      end
      if (bex_req) begin
        bex_taken  <= (status != 32'd0);
        bex_target <= status[26:0];
      end
      if (acc_ovf && (ovf_count != '1)) ovf_count <= ovf_count + 1'b1;
      if (accepted && full && !pop) evt_drop <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_head <= 34'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_head <= mem[rd_ptr];
      end
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {evt_type, new_status};
  end

endmodule

// File: tb/tb_rstatus_unit.sv
// Scoreboard bench for rstatus_unit: drive() models the status register and
// pushes expected log entries; test_drain pops and compares them.
module tb_rstatus_unit;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clock;
  logic             reset_n;
  logic             ovf_valid;
  logic [1:0]       ovf_code;
  logic             setx_valid;
  logic [26:0]      setx_target;
  logic             bex_req;
  logic             bex_taken;
  logic [26:0]      bex_target;
  logic             bex_done;
  logic             rs_we;
  logic [31:0]      rs_data;
  logic [31:0]      status;
  logic             evt_valid;
  logic [33:0]      evt_data;
  logic             evt_ready;
  logic [CNT_W-1:0] ovf_count;
  logic             evt_drop;

  rstatus_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .ovf_valid(ovf_valid), .ovf_code(ovf_code),
    .setx_valid(setx_valid), .setx_target(setx_target),
    .bex_req(bex_req), .bex_taken(bex_taken), .bex_target(bex_target), .bex_done(bex_done),
    .rs_we(rs_we), .rs_data(rs_data), .status(status),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
    .ovf_count(ovf_count), .evt_drop(evt_drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0]      m_status;
  logic [CNT_W-1:0] m_cnt;
  logic             m_drop;
  logic             m_bex_taken;
  logic [26:0]      m_bex_target;
  logic             e_we;
  logic [31:0]      e_wd;
  logic             e_done;
  logic [33:0]      exp_q[$];

  task automatic do_reset;
    reset_n = 1'b0;
    ovf_valid = 1'b0; ovf_code = 2'd0; setx_valid = 1'b0; setx_target = 27'd0;
    bex_req = 1'b0; evt_ready = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    m_status = 32'd0; m_cnt = '0; m_drop = 1'b0;
    m_bex_taken = 1'b0; m_bex_target = 27'd0;
    exp_q.delete();
  endtask

  // One cycle of stimulus; updates the reference model and the log scoreboard.
  task automatic drive(input logic ov, input logic [1:0] code, input logic sx,
                       input logic [26:0] tgt, input logic bq);
    logic acc_ovf, acc_sx, held, upd;
    logic [31:0] nv;
    logic [1:0] ty;
    ovf_valid = ov; ovf_code = code; setx_valid = sx; setx_target = tgt; bex_req = bq;
    acc_ovf = ov && (code != 2'd0);
    acc_sx  = sx && !acc_ovf;
`ifdef RSTATUS_STICKY_EN
    held = (m_status[1:0] != 2'd0) && (m_status[31:2] == 30'd0);
`else
    held = 1'b0;
`endif
    ty = 2'b00; nv = m_status; upd = 1'b0;
    if (acc_ovf) begin
      ty = 2'b01; upd = !held;
      if (!held) nv = {30'd0, code};
    end else if (acc_sx) begin
      ty = 2'b10; upd = 1'b1; nv = {5'd0, tgt};
    end
    e_done = bq;
    if (bq) begin
      m_bex_taken  = (m_status != 32'd0);
      m_bex_target = m_status[26:0];
    end
    e_we = upd;
    if (upd) begin
      e_wd = nv;
      m_status = nv;
    end
    if (acc_ovf && (m_cnt != {CNT_W{1'b1}})) m_cnt = m_cnt + 1'b1;
    if (evt_ready && (exp_q.size() > 0)) exp_q.delete(0);
    if (acc_ovf || acc_sx) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({ty, nv});
      else m_drop = 1'b1;
    end
    @(posedge clock); #1;
    ovf_valid = 1'b0; ovf_code = 2'd0; setx_valid = 1'b0; setx_target = 27'd0; bex_req = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #2;
    n_cmp++;
    if (status !== 32'd0 || rs_we !== 1'b0 || rs_data !== 32'd0) begin
      n_err++; $display("FAIL reset_regs: status=%h rs_we=%b rs_data=%h, want 0/0/0", status, rs_we, rs_data);
    end
    n_cmp++;
    if (bex_taken !== 1'b0 || bex_target !== 27'd0 || bex_done !== 1'b0) begin
      n_err++; $display("FAIL reset_bex: taken=%b target=%h done=%b, want 0/0/0", bex_taken, bex_target, bex_done);
    end
    n_cmp++;
    if (evt_valid !== 1'b0 || ovf_count !== '0 || evt_drop !== 1'b0) begin
      n_err++; $display("FAIL reset_log: evt_valid=%b ovf_count=%0d evt_drop=%b, want 0/0/0", evt_valid, ovf_count, evt_drop);
    end
    do_reset();
  endtask

  task automatic test_ovf;
    do_reset();
    drive(1'b1, 2'd3, 1'b0, 27'd0, 1'b0);
    n_cmp++;
    if (rs_we !== 1'b1 || rs_data !== 32'd3) begin
      n_err++; $display("FAIL ovf_write: rs_we=%b rs_data=%h, want 1/3", rs_we, rs_data);
    end
    n_cmp++;
    if (status !== 32'd3 || ovf_count !== CNT_W'(1)) begin
      n_err++; $display("FAIL ovf_status: status=%h ovf_count=%0d, want 3/1", status, ovf_count);
    end
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_data !== {2'b01, 32'd3}) begin
      n_err++; $display("FAIL ovf_log: valid=%b data=%h, want 1/%h", evt_valid, evt_data, {2'b01, 32'd3});
    end
    drive(1'b0, 2'd0, 1'b0, 27'd0, 1'b0);
    n_cmp++;
    if (rs_we !== 1'b0) begin
      n_err++; $display("FAIL ovf_we_pulse: rs_we=%b, want 0", rs_we);
    end
    drive(1'b1, 2'd0, 1'b0, 27'd0, 1'b0);
    n_cmp++;
    if (rs_we !== 1'b0 || status !== 32'd3 || ovf_count !== CNT_W'(1)) begin
      n_err++; $display("FAIL ovf_code0: rs_we=%b status=%h count=%0d, want 0/3/1", rs_we, status, ovf_count);
    end
  endtask

  task automatic test_bex;
    drive(1'b0, 2'd0, 1'b1, 27'h123, 1'b0);
    n_cmp++;
    if (status !== 32'h123 || rs_we !== 1'b1 || rs_data !== 32'h123) begin
      n_err++; $display("FAIL setx_write: status=%h rs_we=%b rs_data=%h, want 123/1/123", status, rs_we, rs_data);
    end
    drive(1'b0, 2'd0, 1'b0, 27'd0, 1'b1);
    n_cmp++;
    if (bex_done !== 1'b1 || bex_taken !== 1'b1 || bex_target !== 27'h123) begin
      n_err++; $display("FAIL bex_taken: done=%b taken=%b target=%h, want 1/1/123", bex_done, bex_taken, bex_target);
    end
    drive(1'b0, 2'd0, 1'b0, 27'd0, 1'b0);
    n_cmp++;
    if (bex_done !== 1'b0 || bex_taken !== 1'b1 || bex_target !== 27'h123) begin
      n_err++; $display("FAIL bex_hold: done=%b taken=%b target=%h, want 0/1/123", bex_done, bex_taken, bex_target);
    end
    drive(1'b0, 2'd0, 1'b1, 27'd0, 1'b0);
    drive(1'b0, 2'd0, 1'b0, 27'd0, 1'b1);
    n_cmp++;
    if (bex_done !== 1'b1 || bex_taken !== 1'b0 || bex_target !== 27'd0) begin
      n_err++; $display("FAIL bex_not_taken: done=%b taken=%b target=%h, want 1/0/0", bex_done, bex_taken, bex_target);
    end
    drive(1'b1, 2'd2, 1'b0, 27'd0, 1'b1);
    n_cmp++;
    if (bex_taken !== m_bex_taken || bex_target !== m_bex_target || status !== m_status) begin
      n_err++; $display("FAIL bex_read_before_write: taken=%b target=%h status=%h, want %b/%h/%h",
                        bex_taken, bex_target, status, m_bex_taken, m_bex_target, m_status);
    end
  endtask

  task automatic test_collision;
    do_reset();
    drive(1'b1, 2'd1, 1'b1, 27'h7, 1'b0);
    n_cmp++;
    if (status !== 32'd1 || rs_data !== 32'd1 || evt_data !== {2'b01, 32'd1}) begin
      n_err++; $display("FAIL collision: status=%h rs_data=%h evt=%h, want 1/1/%h", status, rs_data, evt_data, {2'b01, 32'd1});
    end
  endtask

  task automatic test_fifo_full;
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      if (i % 2 == 1) drive(1'b1, 2'((i % 3) + 1), 1'b0, 27'd0, 1'b0);
      else drive(1'b0, 2'd0, 1'b1, 27'(32'h100 + i), 1'b0);
      if (i == DEPTH - 1) begin
        n_cmp++;
        if (evt_drop !== 1'b0) begin
          n_err++; $display("FAIL full_no_drop: evt_drop=%b, want 0", evt_drop);
        end
      end
    end
    n_cmp++;
    if (evt_drop !== m_drop || status !== m_status || rs_data !== m_status) begin
      n_err++; $display("FAIL full_drop: drop=%b status=%h rs_data=%h, want %b/%h/%h", evt_drop, status, rs_data, m_drop, m_status, m_status);
    end
    drive(1'b0, 2'd0, 1'b0, 27'd0, 1'b0);
    n_cmp++;
    if (evt_drop !== 1'b1) begin
      n_err++; $display("FAIL drop_sticky: evt_drop=%b, want 1", evt_drop);
    end
  endtask

  task automatic test_full_push_pop;
    do_reset();
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 2'd0, 1'b1, 27'(32'h200 + i), 1'b0);
    evt_ready = 1'b1;
    drive(1'b1, 2'd3, 1'b0, 27'd0, 1'b0);
    evt_ready = 1'b0;
    n_cmp++;
    if (evt_drop !== 1'b0 || evt_valid !== 1'b1 || status !== 32'd3) begin
      n_err++; $display("FAIL full_push_pop: drop=%b valid=%b status=%h, want 0/1/3", evt_drop, evt_valid, status);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    evt_ready = 1'b1;
    drive(1'b1, 2'd1, 1'b0, 27'd0, 1'b0);
    n_cmp++;
    if (evt_valid !== 1'b1 || rs_we !== 1'b1 || rs_data !== 32'd1) begin
      n_err++; $display("FAIL b2b_first: valid=%b rs_we=%b rs_data=%h, want 1/1/1", evt_valid, rs_we, rs_data);
    end
    drive(1'b0, 2'd0, 1'b1, 27'h55, 1'b0);
    n_cmp++;
    if (rs_we !== 1'b1 || rs_data !== 32'h55 || evt_data !== exp_q[0]) begin
      n_err++; $display("FAIL b2b_second: rs_we=%b rs_data=%h evt=%h, want 1/55/%h", rs_we, rs_data, evt_data, exp_q[0]);
    end
    drive(1'b1, 2'd2, 1'b0, 27'd0, 1'b0);
    n_cmp++;
    if (rs_we !== 1'b1 || rs_data !== e_wd) begin
      n_err++; $display("FAIL b2b_third: rs_we=%b rs_data=%h, want 1/%h", rs_we, rs_data, e_wd);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    drive(1'b1, 2'd1, 1'b0, 27'd0, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 27'h31, 1'b0);
    drive(1'b1, 2'd2, 1'b0, 27'd0, 1'b0);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (evt_valid !== 1'b0 || rs_we !== 1'b0 || status !== 32'd0) begin
      n_err++; $display("FAIL mid_reset: valid=%b rs_we=%b status=%h, want 0/0/0", evt_valid, rs_we, status);
    end
    do_reset();
    drive(1'b0, 2'd0, 1'b1, 27'h9, 1'b0);
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_data !== {2'b10, 32'h9}) begin
      n_err++; $display("FAIL post_reset_log: valid=%b data=%h, want 1/%h", evt_valid, evt_data, {2'b10, 32'h9});
    end
  endtask

  task automatic test_saturate;
    do_reset();
    evt_ready = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 2; i++) drive(1'b1, 2'd3, 1'b0, 27'd0, 1'b0);
    evt_ready = 1'b0;
    n_cmp++;
    if (ovf_count !== {CNT_W{1'b1}} || evt_drop !== 1'b0) begin
      n_err++; $display("FAIL saturate: ovf_count=%0d drop=%b, want %0d/0", ovf_count, evt_drop, (1 << CNT_W) - 1);
    end
  endtask

`ifdef RSTATUS_STICKY_EN
  task automatic test_sticky;
    do_reset();
    drive(1'b1, 2'd1, 1'b0, 27'd0, 1'b0);
    drive(1'b1, 2'd3, 1'b0, 27'd0, 1'b0);
    n_cmp++;
    if (status !== 32'd1 || rs_we !== 1'b0 || ovf_count !== CNT_W'(2)) begin
      n_err++; $display("FAIL sticky_hold: status=%h rs_we=%b count=%0d, want 1/0/2", status, rs_we, ovf_count);
    end
    drive(1'b0, 2'd0, 1'b1, 27'd5, 1'b0);
    n_cmp++;
    if (status !== 32'd5 || rs_we !== 1'b1) begin
      n_err++; $display("FAIL sticky_setx: status=%h rs_we=%b, want 5/1", status, rs_we);
    end
  endtask
`endif

  task automatic test_drain;
    logic [33:0] want;
    logic [33:0] last;
    int n;
    n = exp_q.size();
    last = 34'd0;
    evt_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      want = exp_q.pop_front();
      last = want;
      n_cmp++;
      if (evt_valid !== 1'b1 || evt_data !== want) begin
        n_err++; $display("FAIL drain_entry%0d: valid=%b data=%h, want 1/%h", i, evt_valid, evt_data, want);
      end
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    evt_ready = 1'b0;
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_err++; $display("FAIL drain_empty: evt_valid=%b, want 0", evt_valid);
    end
    if (n > 0) begin
      n_cmp++;
      if (evt_data !== last) begin
        n_err++; $display("FAIL drain_hold: evt_data=%h, want %h", evt_data, last);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    ovf_valid = 1'b0; ovf_code = 2'd0; setx_valid = 1'b0; setx_target = 27'd0;
    bex_req = 1'b0; evt_ready = 1'b0;
    test_reset();
    test_ovf();
    test_drain();
    test_bex();
    test_drain();
    test_collision();
    test_drain();
    test_fifo_full();
    test_drain();
    test_full_push_pop();
    test_drain();
    test_back_to_back();
    test_drain();
    test_reset_mid();
    test_drain();
    test_saturate();
    test_drain();
`ifdef RSTATUS_STICKY_EN
    test_sticky();
    test_drain();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rstatus_unit.md
Name: rstatus_unit

Overview:
- Owner and reader of the processor's exception status register ($r30, "rstatus").
- Consumes the overflow code produced alongside each add/sub/addi and the setx writes, and holds the current status value.
- Answers bex branch queries with taken/target.
- Drives the register-file write port for $r30 and logs status events into a small FIFO that a debug/handler port drains with a valid/ready handshake.

Parameters:
- DEPTH, 4, event FIFO entries; power of two, 2..16.
- CNT_W, 8, width of the saturating overflow counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ovf_valid  input  1  overflow occurred on an overflow-checked instruction this cycle.
- ovf_code  input  2  status code: 1=add, 2=addi, 3=sub; 0 is illegal and ignored.
- setx_valid  input  1  setx instruction retiring this cycle.
- setx_target  input  27  setx immediate T.
- bex_req  input  1  bex query this cycle.
- bex_taken  output  1  registered; status register nonzero at query.
- bex_target  output  27  registered; status[26:0] at query.
- bex_done  output  1  one-cycle pulse, cycle after bex_req.
- rs_we  output  1  $r30 write enable to register file.
- rs_data  output  32  $r30 write data.
- status  output  32  current status register value.
- evt_valid  output  1  FIFO non-empty.
- evt_data  output  34  {type[1:0], value[31:0]}; type 01=ovf, 10=setx.
- evt_ready  input  1  consumer pops head when evt_valid && evt_ready.
- ovf_count  output  CNT_W  saturating count of accepted overflows.
- evt_drop  output  1  sticky; an event was lost to a full FIFO.

Behaviour:
- Reset (reset_n low, asynchronous): status=0, rs_we=0, rs_data=0, bex_taken=0, bex_target=0, bex_done=0, FIFO empty (evt_valid=0), ovf_count=0, evt_drop=0. Reset mid-operation discards FIFO contents and any pending write.
- Accepted event: ovf_valid with ovf_code!=0, or setx_valid.
- Overflow accepted at edge N: status <= {30'b0, ovf_code}; ovf_count increments, saturating at all ones.
- setx accepted: status <= {5'b0, setx_target}.
- ovf_valid and setx_valid in the same cycle: overflow wins; the setx is dropped and not logged.
- Register-file write: after each accepted event, rs_we=1 and rs_data=the new status value for exactly the following cycle. Latency is one cycle. Back-to-back events give consecutive write pulses.
- bex: bex_req at edge N samples status as it was before that edge's update, giving read-before-write ordering. In cycle N+1: bex_done=1, bex_taken=(sampled status!=0), bex_target=sampled status[26:0]. bex_taken and bex_target hold until the next bex_req. bex_req together with an event in the same cycle sees the old status.
- FIFO:
  - Each accepted event is pushed as {type, new status}.
  - Pop when evt_valid && evt_ready.
  - Full with push and pop in the same cycle: both occur and count is unchanged.
  - Full with push and no pop: the event is still applied to status and rs_we, but is not logged; evt_drop <= 1 until reset.
  - Empty: evt_data holds its last value; evt_ready is ignored.
  - Pointers wrap modulo DEPTH.
  - Push and pop on an empty FIFO: pop is ignored; the entry becomes visible the next cycle.
- ovf_code==0 with ovf_valid=1: no state change, no write, no log.

Optional Feature:
- Macro: RSTATUS_STICKY_EN.
- Defined: while status[1:0]!=0 and status[31:2]==0 (an overflow code is held), further overflows do not change status and produce no rs_we pulse. They are still counted and logged with the held value. A setx overwrites the held code and clears the stickiness.
- Undefined: every accepted overflow overwrites status as described in Behaviour.

Test Plan:
- Reset, then ovf_valid=1, ovf_code=3 for one cycle -> next cycle rs_we=1, rs_data=3, status=3, ovf_count=1, evt_data={01,32'd3}.
- setx_target=27'h123 then bex_req -> bex_done pulse, bex_taken=1, bex_target=27'h123; setx 0 then bex -> bex_taken=0.
- ovf_code=1 and setx_valid in the same cycle -> status=1, single FIFO entry of type 01, no setx entry.
- Push DEPTH+1 events with evt_ready=0 -> evt_drop=1, FIFO holds the first DEPTH entries in order; status reflects the last event.
- Assert reset_n low while the FIFO holds 3 entries and rs_we=1 -> immediately evt_valid=0, rs_we=0, status=0; the first event after release logs into an empty FIFO.
- With RSTATUS_STICKY_EN defined: ovf 1 then ovf 3 -> status stays 1, one rs_we pulse, ovf_count=2; then setx 5 -> status=5.
